// File: rtl/rmt_ctrl_injector.sv
// rmt_ctrl_injector
//   Transmit side of the RMT control path. Table-write commands are queued in
//   a small FIFO and turned into two-beat control packets (an Ethernet/IPv4/UDP
//   header beat carrying CTRL_UDP_PORT plus the command IDs, then a payload
//   beat carrying cmd_data). Control packets are merged with the data packet
//   stream into one AXI-Stream. Arbitration happens only at packet boundaries
//   and alternates between the two sources on a tie.
//
// Ports
//   clk, aresetn              clock, synchronous active-low reset
//   cmd_valid / cmd_ready     command write strobe / command FIFO not full
//   cmd_mod_id/res_id/idx     target module, resource and table entry index
//   cmd_data                  entry payload (becomes control beat 1)
//   s_axis_*                  data packets in
//   m_axis_*                  merged stream out (single output register stage)
//   cmd_sent_cnt              control packets fully sent (wraps)
//   busy                      FSM not idle or output register holding a beat
module rmt_ctrl_injector #(
  parameter int          C_S_AXIS_DATA_WIDTH  = 512,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter logic [15:0] CTRL_UDP_PORT        = 16'hF1F2,
  parameter int          CMD_FIFO_DEPTH       = 4
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [7:0]                        cmd_mod_id,
  input  logic [3:0]                        cmd_res_id,
  input  logic [7:0]                        cmd_idx,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    cmd_data,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [31:0]                       cmd_sent_cnt,
  output logic                              busy
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam int AW = $clog2(CMD_FIFO_DEPTH);

  localparam logic [UW-1:0] CTRL_TUSER = {{(UW-16){1'b0}}, 16'd128};
  localparam logic          GRANT_DATA = 1'b0;
  localparam logic          GRANT_CTRL = 1'b1;

  typedef struct packed {
    logic [7:0]    mod_id;
    logic [3:0]    res_id;
    logic [7:0]    idx;
    logic [DW-1:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_CTRL0 = 2'd2,
    ST_CTRL1 = 2'd3
  } state_t;

  // Header beat of a control packet: broadcast MAC, IPv4 with protocol UDP,
  // UDP destination port = CTRL_UDP_PORT, then the command IDs.
  function automatic logic [DW-1:0] build_beat0(input cmd_t c);
    logic [DW-1:0] b;
    b = '0;
    for (int k = 0; k < 6; k++) begin
      b[8*k +: 8] = 8'hFF;
    end
    b[8*12 +: 8] = 8'h08;
    b[8*14 +: 8] = 8'h45;
    b[8*23 +: 8] = 8'h11;
    b[8*36 +: 8] = CTRL_UDP_PORT[15:8];
    b[8*37 +: 8] = CTRL_UDP_PORT[7:0];
    b[8*42 +: 8] = c.mod_id;
    b[8*43 +: 8] = {4'h0, c.res_id};
    b[8*44 +: 8] = c.idx;
    return b;
  endfunction

  // ---------------- command FIFO ----------------
  cmd_t          fifo_q [CMD_FIFO_DEPTH];
  cmd_t          fifo_d [CMD_FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          fifo_empty_s, fifo_full_s;
  logic          push_s, pop_s;
  cmd_t          head_s;

  // Extra pointer MSB distinguishes full from empty.
  assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cmd_ready    = aresetn & ~fifo_full_s;
  assign push_s       = cmd_valid & cmd_ready;
  assign head_s       = fifo_q[rd_ptr_q[AW-1:0]];

  // FIFO write side and pointer next-state.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      fifo_d[wr_ptr_q[AW-1:0]] = '{mod_id: cmd_mod_id, res_id: cmd_res_id,
                                   idx: cmd_idx, data: cmd_data};
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  // ---------------- arbiter / packet FSM / output register ----------------
  state_t          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [DW-1:0]   m_tdata_q, m_tdata_d;
  logic [KW-1:0]   m_tkeep_q, m_tkeep_d;
  logic [UW-1:0]   m_tuser_q, m_tuser_d;
  logic            m_tvalid_q, m_tvalid_d;
  logic            m_tlast_q, m_tlast_d;
  logic            ctrl_last_q, ctrl_last_d;   // output holds control beat 1
  logic [31:0]     cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            out_free_s, s_ready_s, m_hs_s;

  assign out_free_s = ~m_tvalid_q | m_axis_tready;
  assign m_hs_s     = m_tvalid_q & m_axis_tready;

  // Next-state, output-register load and counter logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    pop_s        = 1'b0;
    s_ready_s    = 1'b0;
    m_tdata_d    = m_tdata_q;
    m_tkeep_d    = m_tkeep_q;
    m_tuser_d    = m_tuser_q;
    m_tlast_d    = m_tlast_q;
    // A beat that is accepted leaves the register unless replaced below.
    if (m_hs_s) begin
      m_tvalid_d  = 1'b0;
      ctrl_last_d = 1'b0;
      cnt_d       = ctrl_last_q ? (cnt_q + 32'd1) : cnt_q;
    end else begin
      m_tvalid_d  = m_tvalid_q;
      ctrl_last_d = ctrl_last_q;
      cnt_d       = cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (out_free_s) begin
          if (s_axis_tvalid && (fifo_empty_s || (last_grant_q == GRANT_CTRL))) begin
            state_d      = ST_DATA;
            last_grant_d = GRANT_DATA;
          end else if (!fifo_empty_s) begin
            state_d      = ST_CTRL0;
            last_grant_d = GRANT_CTRL;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        s_ready_s = out_free_s;
        if (s_axis_tvalid && out_free_s) begin
          m_tdata_d  = s_axis_tdata;
          m_tkeep_d  = s_axis_tkeep;
          m_tuser_d  = s_axis_tuser;
          m_tlast_d  = s_axis_tlast;
          m_tvalid_d = 1'b1;
          state_d    = s_axis_tlast ? ST_IDLE : ST_DATA;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_CTRL0: begin
        if (out_free_s) begin
          m_tdata_d  = build_beat0(head_s);
          m_tkeep_d  = {KW{1'b1}};
          m_tuser_d  = CTRL_TUSER;
          m_tlast_d  = 1'b0;
          m_tvalid_d = 1'b1;
          state_d    = ST_CTRL1;
        end else begin
          state_d = ST_CTRL0;
        end
      end
      ST_CTRL1: begin
        if (out_free_s) begin
          m_tdata_d   = head_s.data;
          m_tkeep_d   = {KW{1'b1}};
          m_tuser_d   = CTRL_TUSER;
          m_tlast_d   = 1'b1;
          m_tvalid_d  = 1'b1;
          ctrl_last_d = 1'b1;
          pop_s       = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_CTRL1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE) || m_tvalid_d;
  end

  assign s_axis_tready = aresetn & s_ready_s;

  // State, pointer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_CTRL;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      m_tdata_q    <= '0;
      m_tkeep_q    <= '0;
      m_tuser_q    <= '0;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      ctrl_last_q  <= 1'b0;
      cnt_q        <= 32'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      m_tdata_q    <= m_tdata_d;
      m_tkeep_q    <= m_tkeep_d;
      m_tuser_q    <= m_tuser_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tlast_q    <= m_tlast_d;
      ctrl_last_q  <= ctrl_last_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tkeep  = m_tkeep_q;
  assign m_axis_tuser  = m_tuser_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign cmd_sent_cnt  = cnt_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_rmt_ctrl_injector.sv
// Directed testbench for rmt_ctrl_injector.
module tb_rmt_ctrl_injector;

  typedef struct packed {
    logic [511:0] d;
    logic [63:0]  k;
    logic [127:0] u;
    logic         l;
  } beat_t;

  logic         clk = 1'b0;
  logic         aresetn;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [7:0]   cmd_mod_id;
  logic [3:0]   cmd_res_id;
  logic [7:0]   cmd_idx;
  logic [511:0] cmd_data;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic         s_axis_tready;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tready;
  logic [31:0]  cmd_sent_cnt;
  logic         busy;

  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  bit    rnd_en = 1'b0;
  beat_t src[$];
  beat_t got[$];
  beat_t expq[$];
  int    acc_cyc[$];
  int    out_cyc[$];

  rmt_ctrl_injector dut (
    .clk(clk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mod_id(cmd_mod_id), .cmd_res_id(cmd_res_id), .cmd_idx(cmd_idx), .cmd_data(cmd_data),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .cmd_sent_cnt(cmd_sent_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycle index, stable around the rising edge.
  always @(negedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic chk_beat(input string tag, input beat_t o, input beat_t e);
    chk({tag, ".data"}, o.d, e.d);
    chk({tag, ".keep"}, {448'd0, o.k}, {448'd0, e.k});
    chk({tag, ".user"}, {384'd0, o.u}, {384'd0, e.u});
    chk({tag, ".last"}, {511'd0, o.l}, {511'd0, e.l});
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [511:0] hdr(input logic [7:0] m, input logic [3:0] r, input logic [7:0] x);
    logic [511:0] b;
    b = '0;
    b[47:0]      = 48'hFFFF_FFFF_FFFF;
    b[12*8 +: 8] = 8'h08;
    b[14*8 +: 8] = 8'h45;
    b[23*8 +: 8] = 8'h11;
    b[36*8 +: 8] = 8'hF1;
    b[37*8 +: 8] = 8'hF2;
    b[42*8 +: 8] = m;
    b[43*8 +: 8] = {4'h0, r};
    b[44*8 +: 8] = x;
    return b;
  endfunction

  function automatic beat_t mk(input logic [511:0] d, input logic [63:0] k, input logic [127:0] u, input logic l);
    beat_t b;
    b.d = d; b.k = k; b.u = u; b.l = l;
    return b;
  endfunction

  function automatic beat_t dbeat(input int id, input logic l);
    return mk({16{32'hD000_0000 + 32'(id)}}, 64'hF0F0_0000_FFFF_0000 ^ 64'(id),
              {96'hDA7A, 32'(id)}, l);
  endfunction

  task automatic exp_ctrl(input logic [7:0] m, input logic [3:0] r, input logic [7:0] x, input logic [511:0] d);
    expq.push_back(mk(hdr(m, r, x), {64{1'b1}}, 128'd128, 1'b0));
    expq.push_back(mk(d, {64{1'b1}}, 128'd128, 1'b1));
  endtask

  task automatic push_cmd(input logic [7:0] m, input logic [3:0] r, input logic [7:0] x, input logic [511:0] d);
    cmd_mod_id = m; cmd_res_id = r; cmd_idx = x; cmd_data = d;
    cmd_valid = 1'b1;
    step;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_got(input int n, input int maxc, input string tag);
    int c;
    c = 0;
    while (got.size() < n && c < maxc) begin
      step;
      c++;
    end
    chk(tag, got.size(), n);
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, ".count"}, got.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      chk_beat($sformatf("%s[%0d]", tag, i), got[i], expq[i]);
    end
  endtask

  task automatic do_reset;
    aresetn = 1'b0;
    step;
    step;
    aresetn = 1'b1;
    step;
  endtask

  // Data source: presents src[0], pops on handshake, flushes on reset.
  initial begin
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0; s_axis_tlast = 1'b0;
    forever begin
      @(posedge clk);
      if (!aresetn) begin
        src.delete();
      end else if (s_axis_tvalid && s_axis_tready) begin
        void'(src.pop_front());
        acc_cyc.push_back(cyc);
      end
      #1;
      if (src.size() > 0) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = src[0].d; s_axis_tkeep = src[0].k;
        s_axis_tuser  = src[0].u; s_axis_tlast = src[0].l;
      end else begin
        s_axis_tvalid = 1'b0;
      end
    end
  end

  // Random output backpressure while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_en) m_axis_tready = ($urandom_range(0, 1) == 1);
    end
  end

  // Output monitor: records handshakes and checks stability under stall.
  logic         stall_prev = 1'b0;
  logic [511:0] prev_data;
  logic         prev_last;
  always @(posedge clk) begin
    if (aresetn) begin
      if (stall_prev) begin
        chk("stall.valid", {511'd0, m_axis_tvalid}, 512'd1);
        chk("stall.data", m_axis_tdata, prev_data);
        chk("stall.last", {511'd0, m_axis_tlast}, {511'd0, prev_last});
      end
      if (m_axis_tvalid && m_axis_tready) begin
        got.push_back(mk(m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast));
        out_cyc.push_back(cyc);
      end
      stall_prev <= m_axis_tvalid & ~m_axis_tready;
      prev_data  <= m_axis_tdata;
      prev_last  <= m_axis_tlast;
    end else begin
      stall_prev <= 1'b0;
    end
  end

  initial begin
    int    j, di, ci, found;
    beat_t dq[$];
    logic [511:0] cd[$];
    logic [7:0]   cm[$];

    aresetn = 1'b0; cmd_valid = 1'b0; cmd_mod_id = '0; cmd_res_id = '0; cmd_idx = '0; cmd_data = '0;
    m_axis_tready = 1'b1;
    repeat (3) step;

    // ---- reset state ----
    chk("rst.tvalid", {511'd0, m_axis_tvalid}, 512'd0);
    chk("rst.tdata", m_axis_tdata, 512'd0);
    chk("rst.tkeep", {448'd0, m_axis_tkeep}, 512'd0);
    chk("rst.tuser", {384'd0, m_axis_tuser}, 512'd0);
    chk("rst.tlast", {511'd0, m_axis_tlast}, 512'd0);
    chk("rst.s_tready", {511'd0, s_axis_tready}, 512'd0);
    chk("rst.cmd_ready", {511'd0, cmd_ready}, 512'd0);
    chk("rst.cnt", {480'd0, cmd_sent_cnt}, 512'd0);
    chk("rst.busy", {511'd0, busy}, 512'd0);
    aresetn = 1'b1;
    step;
    chk("rst.cmd_ready_after", {511'd0, cmd_ready}, 512'd1);

    // ---- single command: exact latency and beat layout ----
    push_cmd(8'h02, 4'h3, 8'h05, {64{8'hA5}});
    chk("t1.n0_valid", {511'd0, m_axis_tvalid}, 512'd0);
    step;
    chk("t1.n1_valid", {511'd0, m_axis_tvalid}, 512'd0);
    chk("t1.n1_busy", {511'd0, busy}, 512'd1);
    step;
    chk("t1.b0_valid", {511'd0, m_axis_tvalid}, 512'd1);
    chk("t1.b0_byte36", {504'd0, m_axis_tdata[36*8 +: 8]}, 512'hF1);
    chk("t1.b0_byte37", {504'd0, m_axis_tdata[37*8 +: 8]}, 512'hF2);
    chk("t1.b0_byte42", {504'd0, m_axis_tdata[42*8 +: 8]}, 512'h02);
    chk("t1.b0_byte43", {504'd0, m_axis_tdata[43*8 +: 8]}, 512'h03);
    chk("t1.b0_byte44", {504'd0, m_axis_tdata[44*8 +: 8]}, 512'h05);
    chk_beat("t1.b0", mk(m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast),
             mk(hdr(8'h02, 4'h3, 8'h05), {64{1'b1}}, 128'd128, 1'b0));
    step;
    chk("t1.b1_valid", {511'd0, m_axis_tvalid}, 512'd1);
    chk_beat("t1.b1", mk(m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast),
             mk({64{8'hA5}}, {64{1'b1}}, 128'd128, 1'b1));
    step;
    chk("t1.end_valid", {511'd0, m_axis_tvalid}, 512'd0);
    chk("t1.cnt", {480'd0, cmd_sent_cnt}, 512'd1);
    chk("t1.busy", {511'd0, busy}, 512'd0);

    // ---- 3-beat data packet: 1-cycle latency, full throughput ----
    got.delete(); acc_cyc.delete(); out_cyc.delete();
    for (int i = 0; i < 3; i++) src.push_back(dbeat(i, i == 2));
    wait_got(3, 30, "t2.beats");
    for (int i = 0; i < 3; i++) begin
      chk_beat($sformatf("t2[%0d]", i), got[i], dbeat(i, i == 2));
      chk($sformatf("t2.lat[%0d]", i), out_cyc[i], acc_cyc[i] + 1);
      if (i > 0) chk($sformatf("t2.tput[%0d]", i), acc_cyc[i], acc_cyc[i-1] + 1);
    end

    // ---- tie after reset: data first, then grants alternate ----
    do_reset;
    got.delete(); expq.delete();
    src.push_back(dbeat(10, 1'b1));
    src.push_back(dbeat(11, 1'b1));
    push_cmd(8'h31, 4'h1, 8'h41, {16{32'hC1C1_0001}});
    push_cmd(8'h32, 4'h2, 8'h42, {16{32'hC2C2_0002}});
    expq.push_back(dbeat(10, 1'b1));
    exp_ctrl(8'h31, 4'h1, 8'h41, {16{32'hC1C1_0001}});
    expq.push_back(dbeat(11, 1'b1));
    exp_ctrl(8'h32, 4'h2, 8'h42, {16{32'hC2C2_0002}});
    wait_got(6, 60, "t3.beats");
    cmp_stream("t3");

    // ---- FIFO full under backpressure ----
    do_reset;
    got.delete(); expq.delete();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_cmd(8'h10 + 8'(i), 4'(i), 8'h20 + 8'(i), {16{32'hC0DE_0000 + 32'(i)}});
      chk($sformatf("t4.cmd_ready[%0d]", i), {511'd0, cmd_ready}, (i < 3) ? 512'd1 : 512'd0);
      if (i < 4) exp_ctrl(8'h10 + 8'(i), 4'(i), 8'h20 + 8'(i), {16{32'hC0DE_0000 + 32'(i)}});
    end
    step;
    chk("t4.held_valid", {511'd0, m_axis_tvalid}, 512'd1);
    m_axis_tready = 1'b1;
    wait_got(8, 80, "t4.beats");
    step; step; step;
    chk("t4.no_extra", got.size(), 8);
    cmp_stream("t4");
    chk("t4.cnt", {480'd0, cmd_sent_cnt}, 512'd4);

    // ---- mixed traffic with random backpressure ----
    got.delete();
    rnd_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dq.push_back(dbeat(20 + i, (i == 1) || (i == 2) || (i == 5)));
      src.push_back(dbeat(20 + i, (i == 1) || (i == 2) || (i == 5)));
    end
    for (int i = 0; i < 3; i++) begin
      cm.push_back(8'h50 + 8'(i));
      cd.push_back({16{32'hBEEF_0000 + 32'(i)}});
      push_cmd(8'h50 + 8'(i), 4'h7, 8'h60 + 8'(i), {16{32'hBEEF_0000 + 32'(i)}});
    end
    wait_got(12, 1000, "t5.beats");
    rnd_en = 1'b0;
    step;
    m_axis_tready = 1'b1;
    j = 0; di = 0; ci = 0;
    while (j < got.size()) begin
      if (got[j].u == 128'd128) begin
        chk_beat($sformatf("t5.c%0d.b0", ci), got[j], mk(hdr(cm[ci], 4'h7, 8'h60 + 8'(ci)), {64{1'b1}}, 128'd128, 1'b0));
        chk_beat($sformatf("t5.c%0d.b1", ci), got[j+1], mk(cd[ci], {64{1'b1}}, 128'd128, 1'b1));
        ci++;
        j += 2;
      end else begin
        chk_beat($sformatf("t5.d%0d", di), got[j], dq[di]);
        di++;
        j++;
      end
    end
    chk("t5.ctrl_pkts", ci, 3);
    chk("t5.data_beats", di, 6);
    chk("t5.cnt", {480'd0, cmd_sent_cnt}, 512'd7);

    // ---- reset in the middle of a 4-beat data packet ----
    got.delete();
    for (int i = 0; i < 4; i++) src.push_back(dbeat(30 + i, i == 3));
    found = 0;
    for (int c = 0; c < 30 && found == 0; c++) begin
      step;
      if (m_axis_tvalid && m_axis_tdata == dbeat(31, 1'b0).d) found = 1;
    end
    chk("t6.reached_beat2", found, 1);
    aresetn = 1'b0;
    step;
    chk("t6.tvalid", {511'd0, m_axis_tvalid}, 512'd0);
    chk("t6.tdata", m_axis_tdata, 512'd0);
    chk("t6.tkeep", {448'd0, m_axis_tkeep}, 512'd0);
    chk("t6.tuser", {384'd0, m_axis_tuser}, 512'd0);
    chk("t6.tlast", {511'd0, m_axis_tlast}, 512'd0);
    chk("t6.s_tready", {511'd0, s_axis_tready}, 512'd0);
    chk("t6.cmd_ready", {511'd0, cmd_ready}, 512'd0);
    chk("t6.cnt", {480'd0, cmd_sent_cnt}, 512'd0);
    chk("t6.busy", {511'd0, busy}, 512'd0);
    chk("t6.partial_count", got.size(), 1);
    chk_beat("t6.partial", got[0], dbeat(30, 1'b0));
    aresetn = 1'b1;
    step;
    got.delete(); expq.delete();
    src.push_back(dbeat(40, 1'b0));
    src.push_back(dbeat(41, 1'b1));
    expq.push_back(dbeat(40, 1'b0));
    expq.push_back(dbeat(41, 1'b1));
    wait_got(2, 30, "t6.after_beats");
    cmp_stream("t6.after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rmt_ctrl_injector.md
# rmt_ctrl_injector

Builds RMT control packets from a simple command interface and merges them with the data packet stream into the single AXI-Stream that feeds the RMT pipeline input. It is the transmit side of the control path: its control packets carry the UDP destination port that the pipeline's packet filter uses to separate control traffic from data traffic. Arbitration happens only at packet boundaries, so packets are never interleaved.

## Interface
- C_S_AXIS_DATA_WIDTH, 512, stream data width; only 512 is supported.
- C_S_AXIS_TUSER_WIDTH, 128, stream tuser width.
- CTRL_UDP_PORT, 16'hF1F2, UDP destination port written into control packets.
- CMD_FIFO_DEPTH, 4, command FIFO depth; must be a power of 2 and at least 2.

Ports (reset `aresetn`, synchronous, active-low; clock `clk`):
- clk  in  1  clock for all logic
- aresetn  in  1  synchronous active-low reset
- cmd_valid  in  1  command write strobe
- cmd_ready  out  1  command FIFO not full
- cmd_mod_id  in  8  target module ID
- cmd_res_id  in  4  resource ID within the module
- cmd_idx  in  8  table entry index
- cmd_data  in  512  entry payload
- s_axis_tdata/tkeep/tuser/tvalid/tlast  in  512/64/128/1/1  data packets in
- s_axis_tready  out  1
- m_axis_tdata/tkeep/tuser/tvalid/tlast  out  512/64/128/1/1  merged stream out
- m_axis_tready  in  1
- cmd_sent_cnt  out  32  count of control packets fully sent
- busy  out  1  high in any state other than IDLE, or while m_axis_tvalid is high

## Operation
- Command FIFO:
  - A push happens on cmd_valid & cmd_ready; cmd_ready = !fifo_full.
  - When the FIFO is full, cmd_valid is ignored.
  - A command pushed in cycle N can be granted no earlier than cycle N+1.
- Output register: one stage holding all m_axis_* signals.
  - It can load when out_free = !m_axis_tvalid | m_axis_tready.
  - When loaded and not accepted, its contents stay stable until m_axis_tready.
- FSM states: IDLE, DATA, CTRL0, CTRL1.
- IDLE, when out_free:
  - Only s_axis_tvalid pending: go to DATA.
  - Only the FIFO is non-empty: go to CTRL0.
  - Both pending: grant the source not granted last. last_grant resets to CTRL, so data wins the first tie.
  - Neither pending: stay in IDLE.
- DATA:
  - s_axis_tready = out_free; each accepted beat is copied unchanged into the output register.
  - An accepted beat with tlast returns the FSM to IDLE.
  - s_axis_tready is 0 in every other state.
- CTRL0 (when out_free): load beat 0, then go to CTRL1. Beat 0 layout, byte k = tdata[8k+7:8k]:
  - Bytes 0-5 = FF (destination MAC); bytes 6-11 = 00; bytes 12-13 = 08 00.
  - Byte 14 = 45; byte 23 = 11; all other bytes 15-33 = 00.
  - Bytes 34-35 = 00; byte 36 = CTRL_UDP_PORT[15:8]; byte 37 = CTRL_UDP_PORT[7:0]; bytes 38-41 = 00.
  - Byte 42 = mod_id; byte 43 = {4'h0, res_id}; byte 44 = idx; bytes 45-63 = 00.
  - tkeep all ones, tlast 0.
- CTRL1 (when out_free): load beat 1 and pop the FIFO, then go to IDLE.
  - tdata = cmd_data, tkeep all ones, tlast 1.
- tuser on both control beats: [15:0] = 16'd128 (packet length), all other bits 0.
- cmd_sent_cnt increments on the m_axis handshake of control beat 1 and wraps from 2^32-1 to 0.

## Timing
- Reset values:
  - m_axis_tvalid = 0, tdata/tkeep/tuser/tlast = 0, s_axis_tready = 0.
  - cmd_ready = 0 while aresetn = 0, then 1 in the first cycle after reset.
  - cmd_sent_cnt = 0, busy = 0, FSM = IDLE, FIFO empty, last_grant = CTRL.
- Data latency: a beat accepted at cycle N is on m_axis at N+1. Throughput is 1 beat/cycle when m_axis_tready is held high.
- Control latency: with the FIFO non-empty, IDLE with nothing else pending, and m_axis_tready = 1, the grant is at cycle N. Beat 0 is valid at N+2 and beat 1 at N+3.
- The IDLE decision consumes one cycle with no beat transferred.
- Backpressure (m_axis_tready = 0): the FSM holds its state, s_axis_tready = 0, and the output register is unchanged.
- Reset mid-packet: m_axis_tvalid drops in the next cycle and the partial packet is discarded without tlast. Any command in flight is lost.

## Test plan
- Reset, then push one command (mod_id=8'h02, res_id=4'h3, idx=8'h05, data=512'hA5..A5):
  - Required: beat 0 has byte36=F1, byte37=F2, byte42=02, byte43=03, byte44=05.
  - Required: beat 1 has data A5..A5 and tlast=1; tuser[15:0]=128 on both beats; cmd_sent_cnt=1.
- Stream a 3-beat data packet with m_axis_tready=1:
  - Required: identical beats appear 1 cycle after acceptance, and s_axis_tready stays high for the whole packet.
- Data packet and command pending together in IDLE after reset:
  - Required: the data packet is sent first, then the control packet. Repeat: grants alternate.
- Push 5 commands back-to-back while m_axis_tready=0:
  - Required: cmd_ready falls after the 4th push and the 5th is not stored.
  - Release m_axis_tready: exactly 4 control packets are sent, in push order, and cmd_sent_cnt=4.
- Toggle m_axis_tready randomly during mixed traffic:
  - Required: no beat is lost or duplicated, m_axis data is stable while tvalid & !tready, and packets are never interleaved.
- Assert aresetn=0 during beat 2 of a 4-beat data packet:
  - Required: m_axis_tvalid=0 the next cycle, every output returns to its reset value, and the next packet after reset passes unchanged.
